// File: rtl/sync_stage_pkg.sv
// -----------------------------------------------------------------------------
// sync_stage_pkg
// Shared types and constants for the clk2-side event filter.
//   filt_state_e       : glitch-filter FSM state, 2-bit encoding
//   FILT_CYCLES_MIN/MAX: legal range of the qualification length
//   CNT_W_MIN/MAX      : legal range of the event counter width
// -----------------------------------------------------------------------------
package sync_stage_pkg;

    typedef enum logic [1:0] {
        LOW     = 2'd0,
        QUAL_HI = 2'd1,
        HIGH    = 2'd2,
        QUAL_LO = 2'd3
    } filt_state_e;

    localparam int unsigned FILT_CYCLES_MIN = 1;
    localparam int unsigned FILT_CYCLES_MAX = 255;
    localparam int unsigned CNT_W_MIN       = 2;
    localparam int unsigned CNT_W_MAX       = 32;

endpackage : sync_stage_pkg

// File: rtl/edge_event_counter.sv
// -----------------------------------------------------------------------------
// edge_event_counter
// Saturating count of qualified rising events with a sticky overflow flag.
//   clk2       in  : clock
//   rst2       in  : synchronous active-high reset
//   rise_event in  : a rise is being registered on this edge
//   cnt_clr    in  : clear count and overflow (applied before the increment)
//   evt_count  out : saturating event count
//   evt_ovf    out : set when a rise arrives while evt_count is all-ones
// -----------------------------------------------------------------------------
module edge_event_counter
    import sync_stage_pkg::*;
#(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk2,
    input  logic             rst2,
    input  logic             rise_event,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] evt_count,
    output logic             evt_ovf
);

    logic [CNT_W-1:0] count_q, count_d;
    logic             ovf_q, ovf_d;

    // NOTE: every variable gets a default at the top of always_comb so no
    // path through the block can leave it unassigned and infer a latch.
    always_comb begin
        count_d = count_q;
        ovf_d   = ovf_q;
        // Clear first, then count: a clear coinciding with a rise yields 1.
        if (cnt_clr) begin
            count_d = '0;
            ovf_d   = 1'b0;
        end
        if (rise_event) begin
            if (count_d != {CNT_W{1'b1}}) begin
                count_d = count_d + CNT_W'(1);
            end else begin
                ovf_d = 1'b1;
            end
        end
    end

    // NOTE: sequential state is written with non-blocking assignments so all
    // flops sample their _d values from the same edge without ordering races.
    always_ff @(posedge clk2) begin
        if (rst2) begin
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    assign evt_count = count_q;
    assign evt_ovf   = ovf_q;

endmodule : edge_event_counter

// File: rtl/sync_event_filter.sv
// -----------------------------------------------------------------------------
// sync_event_filter
// Debounces an already-synchronized level: a change is accepted only after
// FILT_CYCLES consecutive samples differ from the current filtered level.
//   clk2       in  : sole clock
//   rst2       in  : synchronous active-high reset, overrides everything
//   sync_in    in  : synchronized level (metastability-safe)
//   cnt_clr    in  : one-cycle request to clear evt_count / evt_ovf
//   level_out  out : filtered level
//   rise_pulse out : one cycle high on level_out 0->1
//   fall_pulse out : one cycle high on level_out 1->0
//   evt_count  out : saturating count of rises
//   evt_ovf    out : sticky counter overflow
// All outputs are registered.
// -----------------------------------------------------------------------------
module sync_event_filter
    import sync_stage_pkg::*;
#(
    parameter int unsigned FILT_CYCLES = 4,
    parameter int unsigned CNT_W       = 8
) (
    input  logic             clk2,
    input  logic             rst2,
    input  logic             sync_in,
    input  logic             cnt_clr,
    output logic             level_out,
    output logic             rise_pulse,
    output logic             fall_pulse,
    output logic [CNT_W-1:0] evt_count,
    output logic             evt_ovf
);

    localparam int unsigned QW = $clog2(FILT_CYCLES + 1);
    // qcnt value at which the next agreeing sample completes qualification.
    localparam logic [QW-1:0] QLAST = QW'(FILT_CYCLES - 1);

    if (FILT_CYCLES < FILT_CYCLES_MIN || FILT_CYCLES > FILT_CYCLES_MAX) begin : g_bad_filt
        $error("sync_event_filter: FILT_CYCLES out of range");
    end
    if (CNT_W < CNT_W_MIN || CNT_W > CNT_W_MAX) begin : g_bad_cnt_w
        $error("sync_event_filter: CNT_W out of range");
    end

    filt_state_e   state_q, state_d;
    logic [QW-1:0] qcnt_q, qcnt_d;
    logic          level_q, level_d;
    logic          rise_q, rise_d;
    logic          fall_q, fall_d;

    always_comb begin
        state_d = state_q;
        qcnt_d  = qcnt_q;
        level_d = level_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        unique case (state_q)
            LOW: begin
                if (sync_in) begin
                    if (FILT_CYCLES == 1) begin
                        state_d = HIGH;
                        level_d = 1'b1;
                        rise_d  = 1'b1;
                    end else begin
                        state_d = QUAL_HI;
                        qcnt_d  = QW'(1);
                    end
                end
            end
            QUAL_HI: begin
                if (!sync_in) begin
                    state_d = LOW;
                    qcnt_d  = '0;
                end else if (qcnt_q == QLAST) begin
                    state_d = HIGH;
                    qcnt_d  = '0;
                    level_d = 1'b1;
                    rise_d  = 1'b1;
                end else begin
                    qcnt_d = qcnt_q + QW'(1);
                end
            end
            HIGH: begin
                if (!sync_in) begin
                    if (FILT_CYCLES == 1) begin
                        state_d = LOW;
                        level_d = 1'b0;
                        fall_d  = 1'b1;
                    end else begin
                        state_d = QUAL_LO;
                        qcnt_d  = QW'(1);
                    end
                end
            end
            QUAL_LO: begin
                if (sync_in) begin
                    state_d = HIGH;
                    qcnt_d  = '0;
                end else if (qcnt_q == QLAST) begin
                    state_d = LOW;
                    qcnt_d  = '0;
                    level_d = 1'b0;
                    fall_d  = 1'b1;
                end else begin
                    qcnt_d = qcnt_q + QW'(1);
                end
            end
            default: begin
                state_d = LOW;
                qcnt_d  = '0;
                level_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk2) begin
        if (rst2) begin
            state_q <= LOW;
            qcnt_q  <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            qcnt_q  <= qcnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign level_out  = level_q;
    assign rise_pulse = rise_q;
    assign fall_pulse = fall_q;

    // The counter sees the rise being registered now, so evt_count moves on
    // the same edge that raises rise_pulse.
    edge_event_counter #(
        .CNT_W (CNT_W)
    ) u_counter (
        .clk2       (clk2),
        .rst2       (rst2),
        .rise_event (rise_d),
        .cnt_clr    (cnt_clr),
        .evt_count  (evt_count),
        .evt_ovf    (evt_ovf)
    );

endmodule : sync_event_filter
